// File: rtl/c3_heap_pq.sv
`default_nettype none
// ============================================================================
// Module   : c3_heap_pq
// Brief    : Parametrised binary-heap priority queue for the C3 custom slot;
//            sift FSM walks one tree level per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module c3_heap_pq #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int MAX_HEAP = 0,
    parameter int SIGNED   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_v,
    output logic                       in_ready,
    input  logic [4:0]                 rd,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_v,
    output logic [4:0]                 out_rd,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int c_CW    = $clog2(DEPTH + 1);
    localparam int c_IW    = $clog2(DEPTH);
    localparam int c_XW    = c_IW + 2;
    localparam int c_SLOTS = 1 << c_IW;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_up   = 2'd1;
    localparam logic [1:0] c_st_down = 2'd2;

    localparam logic [2:0] c_op_push  = 3'd0;
    localparam logic [2:0] c_op_pop   = 3'd1;
    localparam logic [2:0] c_op_peek  = 3'd2;
    localparam logic [2:0] c_op_repl  = 3'd3;
    localparam logic [2:0] c_op_clear = 3'd4;
    localparam logic [2:0] c_op_count = 3'd5;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_count;
    logic [c_IW-1:0]  r_idx;
    logic [WIDTH-1:0] r_heap [c_SLOTS];
    logic [WIDTH-1:0] r_res;
    logic [4:0]       r_rd;
    logic             r_out_v;
    logic [4:0]       r_out_rd;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;

    function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic lt;
        logic gt;
        if (SIGNED != 0) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return (MAX_HEAP != 0) ? gt : lt;
    endfunction

    logic [c_CW-1:0]  w_cnt_p1;
    logic [c_CW-1:0]  w_cnt_m1;
    logic [c_IW-1:0]  w_cnt_lo;
    logic [c_IW-1:0]  w_tail;
    logic [WIDTH-1:0] w_cnt_res;
    logic [WIDTH-1:0] w_inc_res;

    assign w_cnt_p1 = r_count + c_CW'(1);
    assign w_cnt_m1 = r_count - c_CW'(1);
    // Both truncations are only consumed when the value is a live slot index.
    assign w_cnt_lo = c_IW'(r_count);
    assign w_tail   = c_IW'(w_cnt_m1);

    generate
        if (WIDTH >= c_CW) begin : g_res_ext
            assign w_cnt_res = WIDTH'(r_count);
            assign w_inc_res = WIDTH'(w_cnt_p1);
        end else begin : g_res_trunc
            assign w_cnt_res = r_count[WIDTH-1:0];
            assign w_inc_res = w_cnt_p1[WIDTH-1:0];
        end
    endgenerate

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_CW'(DEPTH));
    assign count    = r_count;
    assign in_ready = (r_state == c_st_idle);
    assign out_v    = r_out_v;
    assign out_rd   = r_out_rd;
    assign out_data = r_out_data;
    assign out_err  = r_out_err;

    // Tree navigation around the current index
    logic [c_IW-1:0] w_par;
    logic [c_IW-1:0] w_l;
    logic [c_IW-1:0] w_r;
    logic [c_IW-1:0] w_child;
    logic            w_has_l;
    logic            w_has_r;
    logic            w_up_go;
    logic            w_down_go;

    assign w_par     = (r_idx - c_IW'(1)) >> 1;
    assign w_l       = c_IW'({1'b0, r_idx, 1'b1});
    assign w_r       = c_IW'({1'b0, r_idx, 1'b1} + c_XW'(1));
    assign w_has_l   = {1'b0, r_idx, 1'b1} < c_XW'(r_count);
    assign w_has_r   = ({1'b0, r_idx, 1'b1} + c_XW'(1)) < c_XW'(r_count);
    assign w_child   = (w_has_r && better(r_heap[w_r], r_heap[w_l])) ? w_r : w_l;
    assign w_up_go   = (r_idx != '0) && better(r_heap[r_idx], r_heap[w_par]);
    assign w_down_go = w_has_l && better(r_heap[w_child], r_heap[r_idx]);

    logic             w_single;
    logic             w_serr;
    logic [WIDTH-1:0] w_sdata;

    always_comb begin
        w_single = 1'b1;
        w_serr   = 1'b0;
        w_sdata  = '0;
        case (rd[2:0])
            c_op_push:  if (full)  w_serr = 1'b1; else w_single = 1'b0;
            c_op_pop,
            c_op_repl:  if (empty) w_serr = 1'b1; else w_single = 1'b0;
            c_op_peek:  if (empty) w_serr = 1'b1; else w_sdata = r_heap[0];
            c_op_clear: w_sdata = '0;
            c_op_count: w_sdata = w_cnt_res;
            default:    w_serr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_idx      <= '0;
            r_res      <= '0;
            r_rd       <= '0;
            r_out_v    <= 1'b0;
            r_out_rd   <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_out_v <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (in_v) begin
                        r_rd <= rd;
                        if (w_single) begin
                            r_out_v    <= 1'b1;
                            r_out_rd   <= rd;
                            r_out_data <= w_sdata;
                            r_out_err  <= w_serr;
                            if (rd[2:0] == c_op_clear) r_count <= '0;
                        end else if (rd[2:0] == c_op_push) begin
                            r_heap[w_cnt_lo] <= in_data;
                            r_count          <= w_cnt_p1;
                            r_idx            <= w_cnt_lo;
                            r_res            <= w_inc_res;
                            r_state          <= c_st_up;
                        end else if (rd[2:0] == c_op_pop) begin
                            r_res     <= r_heap[0];
                            r_heap[0] <= r_heap[w_tail];
                            r_count   <= w_cnt_m1;
                            r_idx     <= '0;
                            r_state   <= c_st_down;
                        end else begin
                            r_res     <= r_heap[0];
                            r_heap[0] <= in_data;
                            r_idx     <= '0;
                            r_state   <= c_st_down;
                        end
                    end
                end
                c_st_up: begin
                    if (w_up_go) begin
                        r_heap[r_idx] <= r_heap[w_par];
                        r_heap[w_par] <= r_heap[r_idx];
                        r_idx         <= w_par;
                    end else begin
                        r_state    <= c_st_idle;
                        r_out_v    <= 1'b1;
                        r_out_rd   <= r_rd;
                        r_out_data <= r_res;
                        r_out_err  <= 1'b0;
                    end
                end
                c_st_down: begin
                    if (w_down_go) begin
                        r_heap[r_idx]   <= r_heap[w_child];
                        r_heap[w_child] <= r_heap[r_idx];
                        r_idx           <= w_child;
                    end else begin
                        r_state    <= c_st_idle;
                        r_out_v    <= 1'b1;
                        r_out_rd   <= r_rd;
                        r_out_data <= r_res;
                        r_out_err  <= 1'b0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c3_heap_pq.sv
`default_nettype none
// ============================================================================
// Module   : tb_c3_heap_pq
// Brief    : Scoreboard bench for c3_heap_pq across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c3_heap_pq;

    localparam logic [2:0] c_push = 3'd0, c_pop = 3'd1, c_peek = 3'd2, c_repl = 3'd3;
    localparam logic [2:0] c_clear = 3'd4, c_count = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_v;
    logic [4:0]  rd;
    logic [31:0] in_data;

    always #5 clk = ~clk;

    logic        rdy0, ov0, oe0, em0, fu0;
    logic [4:0]  ord0;
    logic [31:0] od0;
    logic [5:0]  cnt0;
    logic        rdy1, ov1, oe1, em1, fu1;
    logic [4:0]  ord1;
    logic [31:0] od1;
    logic [2:0]  cnt1;
    logic        rdy2, ov2, oe2, em2, fu2;
    logic [4:0]  ord2;
    logic [7:0]  od2;
    logic [5:0]  cnt2;

    c3_heap_pq u_def (
        .clk(clk), .reset(reset), .in_v(in_v), .in_ready(rdy0), .rd(rd), .in_data(in_data),
        .out_v(ov0), .out_rd(ord0), .out_data(od0), .out_err(oe0),
        .count(cnt0), .empty(em0), .full(fu0));

    c3_heap_pq #(.DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .in_v(in_v), .in_ready(rdy1), .rd(rd), .in_data(in_data),
        .out_v(ov1), .out_rd(ord1), .out_data(od1), .out_err(oe1),
        .count(cnt1), .empty(em1), .full(fu1));

    c3_heap_pq #(.WIDTH(8), .MAX_HEAP(1), .SIGNED(1)) u_smax (
        .clk(clk), .reset(reset), .in_v(in_v), .in_ready(rdy2), .rd(rd), .in_data(in_data[7:0]),
        .out_v(ov2), .out_rd(ord2), .out_data(od2), .out_err(oe2),
        .count(cnt2), .empty(em2), .full(fu2));

    int          sel = 0;
    logic        m_rdy, m_ov, m_oe, m_em, m_fu;
    logic [4:0]  m_ord;
    logic [31:0] m_od;
    logic [5:0]  m_cnt;

    always_comb begin
        m_rdy = rdy0; m_ov = ov0; m_oe = oe0; m_em = em0; m_fu = fu0;
        m_ord = ord0; m_od = od0; m_cnt = cnt0;
        if (sel == 1) begin
            m_rdy = rdy1; m_ov = ov1; m_oe = oe1; m_em = em1; m_fu = fu1;
            m_ord = ord1; m_od = od1; m_cnt = {3'b000, cnt1};
        end else if (sel == 2) begin
            m_rdy = rdy2; m_ov = ov2; m_oe = oe2; m_em = em2; m_fu = fu2;
            m_ord = ord2; m_od = {24'h0, od2}; m_cnt = cnt2;
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_out_cyc = 0;
    int   ov_total = 0;
    int   acc_cyc = 0;
    int   last_waits = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completion pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (m_ov) begin
            ov_total++;
            last_out_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_v: rd=%0h data=%0h err=%0b, none expected", m_ord, m_od, m_oe);
            end else begin
                mon_e = sb.pop_front();
                if (m_ord !== mon_e.rd || m_oe !== mon_e.err || (mon_e.chk && m_od !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL result: got rd=%0h data=%0h err=%0b, want rd=%0h data=%0h err=%0b",
                             m_ord, m_od, m_oe, mon_e.rd, mon_e.data, mon_e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [4:0] r, input logic [31:0] d, input logic [31:0] ed,
                         input logic ee, input logic chk, input logic want);
        exp_t e;
        int   waits;
        e.rd = r; e.data = ed; e.err = ee; e.chk = chk;
        if (want) sb.push_back(e);
        @(negedge clk);
        in_v = 1'b1; rd = r; in_data = d;
        waits = 0;
        while (!m_rdy && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        if (!m_rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waits);
        end
        last_waits = waits;
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_v = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_v = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
    endtask

    logic [31:0] keys[$];
    int          a16;
    int          prev_acc;
    int          ov_snap;

    initial begin
        reset = 1'b1; in_v = 1'b0; rd = '0; in_data = '0;

        // Reset state on the default configuration
        sel = 0;
        do_reset();
        check("rst_out_v", {31'b0, m_ov}, 32'd0);
        check("rst_out_err", {31'b0, m_oe}, 32'd0);
        check("rst_out_data", m_od, 32'd0);
        check("rst_out_rd", {27'b0, m_ord}, 32'd0);
        check("rst_count", {26'b0, m_cnt}, 32'd0);
        check("rst_empty", {31'b0, m_em}, 32'd1);
        check("rst_full", {31'b0, m_fu}, 32'd0);
        check("rst_in_ready", {31'b0, m_rdy}, 32'd1);

        // Empty-heap single-cycle ops and illegal opcodes
        issue({2'b11, c_count}, 0, 32'd0, 1'b0, 1'b1, 1'b1);
        issue({2'b01, 3'd6}, 0, 32'd0, 1'b1, 1'b1, 1'b1);
        issue({2'b10, 3'd7}, 0, 32'd0, 1'b1, 1'b1, 1'b1);
        issue({2'b00, c_peek}, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        drain();

        // Push/pop sort of 25 random keys
        keys.delete();
        for (int i = 0; i < 25; i++) begin
            logic [31:0] k;
            k = $urandom;
            keys.push_back(k);
            issue({2'b01, c_push}, k, 32'(i + 1), 1'b0, 1'b1, 1'b1);
        end
        drain();
        check("sort_count_full", {26'b0, m_cnt}, 32'd25);
        keys.sort();
        for (int i = 0; i < 25; i++)
            issue({2'b10, c_pop}, 0, keys[i], 1'b0, 1'b1, 1'b1);
        drain();
        check("sort_count_end", {26'b0, m_cnt}, 32'd0);
        check("sort_empty_end", {31'b0, m_em}, 32'd1);

        // Replace and peek
        issue({2'b00, c_push}, 32'd10, 32'd1, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd20, 32'd2, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd30, 32'd3, 1'b0, 1'b1, 1'b1);
        issue({2'b01, c_count}, 0, 32'd3, 1'b0, 1'b1, 1'b1);
        issue({2'b10, c_repl}, 32'd25, 32'd10, 1'b0, 1'b1, 1'b1);
        issue({2'b11, c_peek}, 0, 32'd20, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_pop}, 0, 32'd20, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_pop}, 0, 32'd25, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_pop}, 0, 32'd30, 1'b0, 1'b1, 1'b1);
        drain();

        // Clear after three pushes
        issue({2'b00, c_push}, 32'd5, 32'd1, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd6, 32'd2, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd7, 32'd3, 1'b0, 1'b1, 1'b1);
        issue({2'b10, c_clear}, 0, 32'd0, 1'b0, 1'b1, 1'b1);
        prev_acc = acc_cyc;
        drain();
        check("clear_latency", 32'(last_out_cyc - prev_acc), 32'd1);
        check("clear_count", {26'b0, m_cnt}, 32'd0);
        issue({2'b01, c_pop}, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        drain();

        // Latency: descending pushes always climb to the root
        do_reset();
        for (int i = 0; i < 32; i++) begin
            issue({2'b01, c_push}, 32'(31 - i), 32'(i + 1), 1'b0, 1'b1, 1'b1);
            if (i == 16) a16 = acc_cyc;
            if (i == 17) begin
                check("push16_out_v_latency", 32'(last_out_cyc - a16), 32'd6);
                check("held_accept_on_out_v", 32'(acc_cyc), 32'(last_out_cyc));
                check("in_ready_low_cycles", 32'(last_waits), 32'd5);
            end
            if (i > 0)
                check("push_spacing", 32'(acc_cyc - prev_acc), 32'($clog2(i + 1) + 1));
            prev_acc = acc_cyc;
        end
        drain();
        check("lat_full", {31'b0, m_fu}, 32'd1);
        check("lat_count", {26'b0, m_cnt}, 32'd32);
        issue({2'b10, c_peek}, 0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 32; i++)
            issue({2'b11, c_pop}, 0, 32'(i), 1'b0, 1'b1, 1'b1);
        issue({2'b11, c_pop}, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        drain();

        // Reset during the sift-down of a pop
        do_reset();
        for (int i = 1; i <= 5; i++)
            issue({2'b00, c_push}, 32'(i), 32'(i), 1'b0, 1'b1, 1'b1);
        drain();
        ov_snap = ov_total;
        issue({2'b01, c_pop}, 0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("midsift_no_out_v", 32'(ov_total - ov_snap), 32'd0);
        check("midsift_count", {26'b0, m_cnt}, 32'd0);
        check("midsift_empty", {31'b0, m_em}, 32'd1);

        // Full/empty boundaries at DEPTH=4
        sel = 1;
        do_reset();
        issue({2'b00, c_push}, 32'd7, 32'd1, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd3, 32'd2, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd9, 32'd3, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'd1, 32'd4, 1'b0, 1'b1, 1'b1);
        drain();
        check("d4_count", {26'b0, m_cnt}, 32'd4);
        check("d4_full", {31'b0, m_fu}, 32'd1);
        issue({2'b01, c_push}, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
        drain();
        check("d4_count_after_err", {26'b0, m_cnt}, 32'd4);
        issue({2'b10, c_pop}, 0, 32'd1, 1'b0, 1'b1, 1'b1);
        issue({2'b10, c_pop}, 0, 32'd3, 1'b0, 1'b1, 1'b1);
        issue({2'b10, c_pop}, 0, 32'd7, 1'b0, 1'b1, 1'b1);
        issue({2'b10, c_pop}, 0, 32'd9, 1'b0, 1'b1, 1'b1);
        issue({2'b11, c_pop}, 0, 32'd0, 1'b1, 1'b0, 1'b1);
        drain();
        check("d4_empty", {31'b0, m_em}, 32'd1);

        // Signed max-heap, WIDTH=8
        sel = 2;
        do_reset();
        issue({2'b00, c_push}, 32'hF0, 32'd1, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'h05, 32'd2, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'h80, 32'd3, 1'b0, 1'b1, 1'b1);
        issue({2'b00, c_push}, 32'h7F, 32'd4, 1'b0, 1'b1, 1'b1);
        issue({2'b01, c_pop}, 0, 32'h7F, 1'b0, 1'b1, 1'b1);
        issue({2'b01, c_pop}, 0, 32'h05, 1'b0, 1'b1, 1'b1);
        issue({2'b01, c_pop}, 0, 32'hF0, 1'b0, 1'b1, 1'b1);
        issue({2'b01, c_pop}, 0, 32'h80, 1'b0, 1'b1, 1'b1);
        drain();
        check("smax_empty", {31'b0, m_em}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/c3_heap_pq.md
# c3_heap_pq

Parametrised priority-queue custom-instruction unit for the C3 custom-instruction slot. It is the next generation of the single-mode push/pop heap unit, and adds configurable key width, depth and ordering (min/max, signed/unsigned). It also adds peek, replace, clear and count operations, a ready/valid handshake, and error signalling on full/empty. Storage is a register-array binary heap maintained by a sift FSM that moves one tree level per cycle.

## Interface
Parameters:
- WIDTH, 32, key width in bits (≥1)
- DEPTH, 32, maximum element count (≥2; need not be a power of 2)
- MAX_HEAP, 0, 0 = min-heap (smallest at root), 1 = max-heap
- SIGNED, 0, 1 = keys compared as two's-complement

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- in_v  in  1  operation request valid
- in_ready  out  1  unit can accept an operation; high only in IDLE
- rd  in  5  opcode in rd[2:0]; rd[4:3] ignored but echoed
- in_data  in  WIDTH  key for push/replace
- out_v  out  1  one-cycle completion pulse
- out_rd  out  5  rd of the completed operation
- out_data  out  WIDTH  operation result
- out_err  out  1  valid with out_v; operation rejected, heap unchanged
- count  out  $clog2(DEPTH+1)  live element count
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Opcodes (rd[2:0]):
  - 0 PUSH: result = new count.
  - 1 POP: result = root.
  - 2 PEEK: result = root.
  - 3 REPLACE: result = old root; root ← in_data, then sift down.
  - 4 CLEAR: count ← 0; result = 0.
  - 5 COUNT: result = count, zero-extended or truncated to WIDTH.
  - 6, 7: out_err = 1, result 0.
- "better(a,b)":
  - a < b for min-heap, a > b for max-heap.
  - Comparison is signed per SIGNED.
  - Equal keys are never swapped.
- FSM states:
  - IDLE: accepts when in_v & in_ready.
  - SIFT_UP: compares heap[idx] with heap[(idx-1)/2].
    - Terminates if idx == 0 or !better(heap[idx], parent).
    - Otherwise swaps and sets idx ← parent.
  - SIFT_DOWN: picks the better existing child of idx (left on tie).
    - Terminates if there is no child or !better(child, heap[idx]).
    - Otherwise swaps and sets idx ← child.
  - Every termination returns to IDLE and sets out_v.
- PUSH on accept: heap[count] ← in_data, count++, idx ← old count, go to SIFT_UP.
- POP on accept: capture root, heap[0] ← heap[count-1], count--, idx ← 0, go to SIFT_DOWN.
- Error cases (out_err = 1, heap and count unchanged, handled as single-cycle):
  - PUSH when full.
  - POP, PEEK or REPLACE when empty.
- POP with count == 1: result = root, count → 0, SIFT_DOWN terminates at once.
- Contents of slots ≥ count are don't-care and are never output.

## Timing
- Reset (reset = 0 at an edge):
  - state IDLE, count 0, empty 1, full 0.
  - out_v 0, out_err 0, out_data 0, out_rd 0.
  - in_ready 1 from the first cycle after reset is released.
- Reset mid-sift: the operation is abandoned, no out_v, heap emptied.
- Accept cycle T:
  - Single-cycle ops (PEEK, CLEAR, COUNT, illegal, all error cases): out_v at T+1.
  - Sift ops (PUSH/POP/REPLACE): SIFT cycles T+1..T+k, out_v at T+k+1.
  - k ≥ 1, since the terminating compare counts as a cycle.
  - Worst case k = floor(log2(DEPTH)) + 1.
- Back-to-back:
  - in_ready rises in the same cycle out_v is high.
  - A new request can be accepted in that cycle.
- in_v while in_ready is low is ignored. The requester holds its request until accepted.
- count, empty and full are registered and update the cycle after accept. They already reflect the operation during its sift cycles.
- out_data, out_rd and out_err are stable while out_v = 1 and hold their value until the next completion.

## Test plan
- Push and pop sort:
  - Stimulus: default params, reset, PUSH 25 $random keys, then 25 POPs.
  - Required: POP results are non-decreasing unsigned and form the same multiset as the pushes.
  - Required: final count 0, empty 1, no out_err.
- Full and empty boundaries:
  - Stimulus: DEPTH=4, PUSH 7,3,9,1, then a 5th PUSH of 5.
  - Required: count 4, full 1; the 5th push gives out_err 1 and count stays 4.
  - Stimulus: POP ×4, then a 5th POP.
  - Required: POPs give 1,3,7,9; the 5th POP gives out_err 1.
- Replace and peek:
  - Stimulus: PUSH 10,20,30, then REPLACE 25, then PEEK.
  - Required: REPLACE returns 10, PEEK returns 20.
  - Required: subsequent POPs give 20,25,30.
- Signed max-heap:
  - Stimulus: MAX_HEAP=1, SIGNED=1, WIDTH=8, PUSH 8'hF0 (-16), 8'h05, 8'h80 (-128), 8'h7F.
  - Required: POPs give 8'h7F, 8'h05, 8'hF0, 8'h80.
- Latency and handshake:
  - Stimulus: DEPTH=32, PUSH keys 31 down to 0 in min-heap.
  - Required: every push sifts to the root; the push at count 16 shows out_v at T+6.
  - Required: in_ready is low during sift; an in_v held during sift is accepted the cycle out_v rises.
- Reset and clear:
  - Stimulus: reset asserted during the SIFT_DOWN of a POP.
  - Required: no out_v, count 0.
  - Stimulus: CLEAR after 3 pushes.
  - Required: out_v at T+1, count 0; a following POP gives out_err.
